uart_rx_fifo: RTL and testbench

Serial receiver with a receive FIFO: the receive-side counterpart of the UART transmit path. It samples an asynchronous serial line (idle high, start 0, LSB-first data, stop 1s) at mid-bit using a clock-count bit timer. Each correctly framed word is pushed into a FIFO that the host drains with a read strobe. Framing errors, overruns and false starts are detected and reported.

---
 rtl/uart_rx_fifo_pkg.sv | 11 +
 rtl/fifo.sv | 66 ++++++
 rtl/uart_receiver.sv | 119 +++++++++++
 rtl/uart_rx_fifo.sv | 67 ++++++
 tb/tb_uart_rx_fifo.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// Shared types for the UART receive path.
package uart_rx_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/fifo.sv
// Synchronous FIFO, first-word fall-through, registered full/empty flags.
module fifo #(
  parameter int B = 8,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rd,
  input  logic         wr,
  input  logic [B-1:0] w_data,
  output logic [B-1:0] r_data,
  output logic         empty,
  output logic         full
);

  logic [B-1:0] mem_q [2**W];
  logic [W-1:0] w_q, w_d, r_q, r_d;
  logic [W-1:0] w_succ, r_succ;
  logic         full_q, full_d, empty_q, empty_d;
  logic         do_rd, do_wr;

  // A read on an empty FIFO is dropped; a write while full only lands if the head pops.
  assign do_rd  = rd & ~empty_q;
  assign do_wr  = wr & (~full_q | do_rd);
  assign w_succ = w_q + W'(1);
  assign r_succ = r_q + W'(1);

  always_comb begin
    w_d     = w_q;
    r_d     = r_q;
    full_d  = full_q;
    empty_d = empty_q;
    if (do_wr) w_d = w_succ;
    if (do_rd) r_d = r_succ;
    if (do_wr && !do_rd) begin
      empty_d = 1'b0;
      full_d  = (w_succ == r_q);
    end else if (do_rd && !do_wr) begin
      full_d  = 1'b0;
      empty_d = (r_succ == w_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_q     <= '0;
      r_q     <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      w_q     <= w_d;
      r_q     <= r_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[w_q] <= w_data;
  end

  assign r_data = mem_q[r_q];
  assign empty  = empty_q;
  assign full   = full_q;

endmodule

// File: rtl/uart_receiver.sv
// UART deserializer: line synchronizer, mid-bit sampling FSM and shift register.
module uart_receiver
  import uart_rx_fifo_pkg::*;
#(
  parameter int P     = 0,
  parameter int s     = 1,
  parameter int TIMER = 434
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rdi,
  output logic [7+P:0] rx_data,
  output logic         rx_done,
  output logic         frame_err
);

  localparam int NB = 8 + P;
  localparam int CW = $clog2(TIMER);
  localparam logic [CW-1:0] HALF_M1   = CW'(TIMER / 2 - 1);
  localparam logic [CW-1:0] FULL_M1   = CW'(TIMER - 1);
  localparam logic [3:0]    LAST_BIT  = 4'(NB - 1);
  localparam logic          LAST_STOP = 1'(s - 1);

  rx_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      bit_q, bit_d;
  logic            stop_q, stop_d;
  logic [NB-1:0]   data_q, data_d;
  logic            sync1_q, sync2_q, prev_q;
  logic            ferr_q, ferr_d;
  logic            fall;

  assign fall = prev_q & ~sync2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rdi;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    stop_d  = stop_q;
    data_d  = data_q;
    ferr_d  = 1'b0;
    rx_done = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (fall) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          bit_d = '0;
          state_d = sync2_q ? IDLE : DATA;
        end
      end
      DATA: begin
        // Right-shift fill leaves the first (LSB) bit at position 0 after NB samples.
        if (cnt_q == FULL_M1) begin
          cnt_d  = '0;
          data_d = {sync2_q, data_q[NB-1:1]};
          if (bit_q == LAST_BIT) begin
            stop_d  = 1'b0;
            state_d = STOP;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (!sync2_q) begin
            ferr_d  = 1'b1;
            state_d = IDLE;
          end else if (stop_q == LAST_STOP) begin
            rx_done = 1'b1;
            state_d = IDLE;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      data_q  <= '0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      data_q  <= data_d;
      ferr_q  <= ferr_d;
    end
  end

  assign rx_data   = data_q;
  assign frame_err = ferr_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver feeding a host-drained FIFO, with overrun detection.
module uart_rx_fifo #(
  parameter int P     = 0,
  parameter int W     = 4,
  parameter int s     = 1,
  parameter int TIMER = 434
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rdi,
  input  logic         rd,
  output logic [7+P:0] r_data,
  output logic         empty,
  output logic         full,
  output logic         rx_tick,
  output logic         frame_err,
  output logic         overrun
);

  logic [7+P:0] rx_data;
  logic         rx_done, push;
  logic         rx_tick_q, overrun_q;

  uart_receiver #(
    .P    (P),
    .s    (s),
    .TIMER(TIMER)
  ) u_rx (
    .clk      (clk),
    .reset    (reset),
    .rdi      (rdi),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .frame_err(frame_err)
  );

  // A full FIFO still accepts the word if the host pops the head on the same edge.
  assign push = rx_done & (~full | rd);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_tick_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      rx_tick_q <= push;
      overrun_q <= rx_done & full & ~rd;
    end
  end

  fifo #(
    .B(8 + P),
    .W(W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .rd    (rd),
    .wr    (push),
    .w_data(rx_data),
    .r_data(r_data),
    .empty (empty),
    .full  (full)
  );

  assign rx_tick = rx_tick_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench: 8N1 instance (dut0) and 9-bit/2-stop instance (dut1), TIMER=16, W=2.
module tb_uart_rx_fifo;

  localparam int T = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rdi0 = 1'b1, rd0 = 1'b0;
  logic       rdi1 = 1'b1, rd1 = 1'b0;
  logic [7:0] r_data0;
  logic [8:0] r_data1;
  logic       empty0, full0, rx_tick0, frame_err0, overrun0;
  logic       empty1, full1, rx_tick1, frame_err1, overrun1;

  int total = 0;
  int bad = 0;
  int tick_n, tick_at, ferr_n, ferr_at, ovr_n, ovr_at;
  int glitch_n;

  always #5 clk = ~clk;

  uart_rx_fifo #(.P(0), .W(2), .s(1), .TIMER(T)) dut0 (
    .clk(clk), .reset(reset), .rdi(rdi0), .rd(rd0), .r_data(r_data0),
    .empty(empty0), .full(full0), .rx_tick(rx_tick0), .frame_err(frame_err0),
    .overrun(overrun0)
  );

  uart_rx_fifo #(.P(1), .W(2), .s(2), .TIMER(T)) dut1 (
    .clk(clk), .reset(reset), .rdi(rdi1), .rd(rd1), .r_data(r_data1),
    .empty(empty1), .full(full1), .rx_tick(rx_tick1), .frame_err(frame_err1),
    .overrun(overrun1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one frame; iteration i samples state after the i-th edge since the start bit.
  task automatic send(input bit sel, input logic [8:0] data, input int nb, input int ns,
                      input bit stop_val, input int pad, input int rd_at);
    logic [15:0] sh;
    logic t, f, o;
    sh = '1;
    sh[0] = 1'b0;
    for (int j = 0; j < nb; j++) sh[4'(1 + j)] = data[4'(j)];
    for (int j = 0; j < ns; j++) sh[4'(1 + nb + j)] = stop_val;
    tick_n = 0; tick_at = -1; ferr_n = 0; ferr_at = -1; ovr_n = 0; ovr_at = -1;
    for (int i = 0; i < (1 + nb + ns) * T + pad; i++) begin
      if (i != 0 && i % T == 0) sh = {1'b1, sh[15:1]};
      if (sel) begin rdi1 = sh[0]; rd1 = (i == rd_at); end
      else     begin rdi0 = sh[0]; rd0 = (i == rd_at); end
      @(negedge clk);
      t = sel ? rx_tick1 : rx_tick0;
      f = sel ? frame_err1 : frame_err0;
      o = sel ? overrun1 : overrun0;
      if (t) begin tick_n++; if (tick_at < 0) tick_at = i; end
      if (f) begin ferr_n++; if (ferr_at < 0) ferr_at = i; end
      if (o) begin ovr_n++;  if (ovr_at < 0)  ovr_at = i;  end
      @(posedge clk);
      #1;
    end
    rd0 = 1'b0;
    rd1 = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (rx_tick0 | frame_err0 | overrun0 | rx_tick1 | frame_err1 | overrun1) glitch_n++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pop(input bit sel);
    if (sel) rd1 = 1'b1; else rd0 = 1'b1;
    @(posedge clk);
    #1;
    rd0 = 1'b0;
    rd1 = 1'b0;
  endtask

  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_empty", empty0, 1);
    chk("rst_full", full0, 0);
    chk("rst_pulses", {rx_tick0, frame_err0, overrun0}, 0);
    chk("rst_empty1", empty1, 1);
    reset = 1'b0;
    idle(4);

    // Single frame 0xA5: push at 3 + T/2 + 9*T = 155
    send(0, 9'h0A5, 8, 1, 1, 4, -1);
    chk("a5_ticks", tick_n, 1);
    chk("a5_latency", tick_at, 155);
    chk("a5_noerr", ferr_n + ovr_n, 0);
    chk("a5_empty", empty0, 0);
    chk("a5_data", r_data0, 8'hA5);
    pop(0);
    chk("a5_drained", empty0, 1);

    // False start: 4-cycle glitch
    glitch_n = 0;
    rdi0 = 1'b0;
    idle(4);
    rdi0 = 1'b1;
    idle(40);
    chk("glitch_pulses", glitch_n, 0);
    chk("glitch_empty", empty0, 1);

    // Framing error on 0x3C
    send(0, 9'h03C, 8, 1, 0, 4, -1);
    chk("ferr_count", ferr_n, 1);
    chk("ferr_at", ferr_at, 155);
    chk("ferr_ticks", tick_n, 0);
    chk("ferr_empty", empty0, 1);

    // Overrun: five back-to-back words into a 4-deep FIFO
    for (int k = 1; k <= 4; k++) begin
      send(0, 9'(k), 8, 1, 1, 0, -1);
      chk("ovr_fill_tick", tick_n, 1);
    end
    chk("ovr_full", full0, 1);
    send(0, 9'h005, 8, 1, 1, 4, -1);
    chk("ovr_pulse", ovr_n, 1);
    chk("ovr_at", ovr_at, 155);
    chk("ovr_noticks", tick_n, 0);
    for (int k = 1; k <= 4; k++) begin
      chk("ovr_read", r_data0, k);
      pop(0);
    end
    chk("ovr_drained", empty0, 1);

    // Push coinciding with a read while full
    for (int k = 1; k <= 4; k++) send(0, 9'(k), 8, 1, 1, 0, -1);
    chk("prd_full_before", full0, 1);
    send(0, 9'h005, 8, 1, 1, 4, 154);
    chk("prd_tick", tick_n, 1);
    chk("prd_no_ovr", ovr_n, 0);
    chk("prd_full_after", full0, 1);
    for (int k = 2; k <= 5; k++) begin
      chk("prd_read", r_data0, k);
      pop(0);
    end
    chk("prd_drained", empty0, 1);

    // Reset in the middle of a frame, with one word already queued
    send(0, 9'h077, 8, 1, 1, 4, -1);
    chk("mid_queued", empty0, 0);
    rdi0 = 1'b0;
    repeat (40) begin @(posedge clk); #1; end
    reset = 1'b1;
    rdi0 = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    chk("mid_empty", empty0, 1);
    chk("mid_full", full0, 0);
    chk("mid_pulses", {rx_tick0, frame_err0, overrun0}, 0);
    reset = 1'b0;
    glitch_n = 0;
    idle(300);
    chk("mid_quiet", glitch_n, 0);

    // 9-bit word with two stop bits: push at 3 + T/2 + 11*T = 187
    send(1, 9'h1FF, 9, 2, 1, 4, -1);
    chk("p1_ticks", tick_n, 1);
    chk("p1_latency", tick_at, 187);
    chk("p1_noerr", ferr_n + ovr_n, 0);
    chk("p1_data", r_data1, 9'h1FF);
    send(1, 9'h12A, 9, 2, 1, 4, -1);
    chk("p1b_ticks", tick_n, 1);
    pop(1);
    chk("p1b_data", r_data1, 9'h12A);
    pop(1);
    chk("p1_drained", empty1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
